morse_key_timer: RTL

- Upstream front end of the morse decoder FSM.
- Samples a raw telegraph key, debounces it, and times press and release intervals.
- Emits one classified symbol per keypress: 1 = dot, 0 = dash, the same encoding as the decoder's `in`. Also emits letter-boundary and abort strobes that drive the decoder's symbol input and its reset.

---
 rtl/morse_pkg.sv | 15 +
 rtl/key_debounce.sv | 44 ++++
 rtl/morse_key_timer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared types for the morse front end and decoder: timer FSM states and symbol encoding.
// Symbol values match the decoder's `in` input so the two blocks can be wired directly.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic SYM_DOT  = 1'b1;
    localparam logic SYM_DASH = 1'b0;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus debounce filter for the raw key.
// key_db follows key_in after 2 + DEBOUNCE_CYCLES cycles of stable input.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic key_db
);

    localparam int             DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]  LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          key_m;
    logic          key_s;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_m <= 1'b0;
            key_s <= 1'b0;
        end else begin
            key_m <= key_in;
            key_s <= key_m;
        end
    end

    // cnt holds how many consecutive edges have already seen a mismatch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            key_db <= 1'b0;
        end else if (key_s == key_db) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt    <= '0;
            key_db <= key_s;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/morse_key_timer.sv
// Debounces a telegraph key and classifies each press as dot/dash, with letter-end and abort strobes.
// All outputs are registered; a symbol strobes one cycle after the debounced release is seen.
module morse_key_timer
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DOT_MAX         = 16,
    parameter int DASH_MAX        = 64,
    parameter int LETTER_GAP      = 48,
    parameter int MAX_SYMS        = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_in,
    output logic       sym_valid,
    output logic       sym,
    output logic       letter_end,
    output logic       abort,
    output logic [2:0] sym_cnt
);

    localparam logic [CNT_W-1:0] DOT_C  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] DASH_C = CNT_W'(DASH_MAX);
    localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(LETTER_GAP);
    localparam logic [2:0]       SYMS_C = 3'(MAX_SYMS);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    // Reset asserts asynchronously but releases on a clock edge
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    logic key_db;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk   (clk),
        .reset (rst_n),
        .key_in(key_in),
        .key_db(key_db)
    );

    state_t           state, state_n;
    logic [CNT_W-1:0] press_cnt, press_n;
    logic [CNT_W-1:0] gap_cnt, gap_n;
    logic [2:0]       sym_cnt_n;
    logic             sym_n, sym_valid_n, letter_end_n, abort_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            press_cnt  <= '0;
            gap_cnt    <= '0;
            sym_cnt    <= '0;
            sym        <= 1'b0;
            sym_valid  <= 1'b0;
            letter_end <= 1'b0;
            abort      <= 1'b0;
        end else begin
            state      <= state_n;
            press_cnt  <= press_n;
            gap_cnt    <= gap_n;
            sym_cnt    <= sym_cnt_n;
            sym        <= sym_n;
            sym_valid  <= sym_valid_n;
            letter_end <= letter_end_n;
            abort      <= abort_n;
        end
    end

    always_comb begin
        state_n      = state;
        press_n      = press_cnt;
        gap_n        = gap_cnt;
        sym_cnt_n    = sym_cnt;
        sym_n        = sym;
        sym_valid_n  = 1'b0;
        letter_end_n = 1'b0;
        abort_n      = 1'b0;

        case (state)
            IDLE: begin
                if (key_db) begin
                    state_n   = PRESS;
                    press_n   = ONE_C;
                    gap_n     = '0;
                    sym_cnt_n = '0;
                end
            end
            PRESS: begin
                if (key_db) begin
                    if (press_cnt >= DASH_C) begin
                        abort_n = 1'b1;
                        gap_n   = '0;
                        state_n = DRAIN;
                    end else begin
                        press_n = press_cnt + 1'b1;
                    end
                end else if (sym_cnt < SYMS_C) begin
                    sym_valid_n = 1'b1;
                    sym_n       = (press_cnt <= DOT_C) ? SYM_DOT : SYM_DASH;
                    sym_cnt_n   = sym_cnt + 1'b1;
                    gap_n       = ONE_C;
                    state_n     = GAP;
                end else begin
                    // One symbol too many: discard the letter and wait for silence
                    abort_n = 1'b1;
                    gap_n   = ONE_C;
                    state_n = DRAIN;
                end
            end
            GAP: begin
                if (key_db) begin
                    state_n = PRESS;
                    press_n = ONE_C;
                    gap_n   = '0;
                end else if (gap_cnt >= GAP_C) begin
                    letter_end_n = 1'b1;
                    sym_cnt_n    = '0;
                    gap_n        = '0;
                    state_n      = IDLE;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (key_db) begin
                    gap_n = '0;
                end else if (gap_cnt >= GAP_C) begin
                    sym_cnt_n = '0;
                    gap_n     = '0;
                    state_n   = IDLE;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
